exec_ctrl: RTL and testbench

Multi-cycle execute sequencer for the integer datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes OP (R-type) and OP-IMM (I-type) encodings. It reads the register file, drives the combinational ALU's operands and funct fields, then writes the result back. It sits between fetch and the register file/ALU pair, and is the only owner of the ALU control inputs.

---
 rtl/exec_ctrl_pkg.sv | 38 +++
 rtl/exec_ctrl_if.sv | 38 +++
 rtl/exec_ctrl_imm_gen.sv | 11 +
 rtl/exec_ctrl.sv | 121 ++++++++++++
 tb/tb_exec_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execute sequencer: ALU encodings,
// supported opcodes and the controller state enumeration.
package exec_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_funct3_e;

    typedef enum logic [6:0] {
        F7_DEFAULT = 7'b0000000,
        F7_NEG     = 7'b0100000
    } alu_funct7_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } exec_state_e;

    function automatic logic opc_supported(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Bundle of fetch handshake, register-file and ALU connections of exec_ctrl.
// The master side is the controller; the slave side is its environment.
interface exec_ctrl_if;
    import exec_ctrl_pkg::*;

    logic                  instr_valid_i;
    logic [XLEN-1:0]       instr_i;
    logic                  instr_ready_o;
    logic [REG_ADDR_W-1:0] rs1_addr_o;
    logic [REG_ADDR_W-1:0] rs2_addr_o;
    logic [XLEN-1:0]       rs1_data_i;
    logic [XLEN-1:0]       rs2_data_i;
    logic [XLEN-1:0]       alu_operand_1_o;
    logic [XLEN-1:0]       alu_operand_2_o;
    alu_funct7_e           alu_funct7_o;
    alu_funct3_e           alu_funct3_o;
    logic [XLEN-1:0]       alu_result_i;
    logic                  rd_we_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [XLEN-1:0]       rd_data_o;
    logic                  illegal_o;
    logic                  busy_o;

    modport master (
        input  instr_valid_i, instr_i, rs1_data_i, rs2_data_i, alu_result_i,
        output instr_ready_o, rs1_addr_o, rs2_addr_o, alu_operand_1_o,
               alu_operand_2_o, alu_funct7_o, alu_funct3_o, rd_we_o,
               rd_addr_o, rd_data_o, illegal_o, busy_o
    );

    modport slave (
        output instr_valid_i, instr_i, rs1_data_i, rs2_data_i, alu_result_i,
        input  instr_ready_o, rs1_addr_o, rs2_addr_o, alu_operand_1_o,
               alu_operand_2_o, alu_funct7_o, alu_funct3_o, rd_we_o,
               rd_addr_o, rd_data_o, illegal_o, busy_o
    );

endinterface

// File: rtl/exec_ctrl_imm_gen.sv
// I-type immediate generator: sign-extends instr[31:20] to the datapath width.
module exec_ctrl_imm_gen
    import exec_ctrl_pkg::*;
(
    input  logic [11:0]     imm12_i,
    output logic [XLEN-1:0] imm_o
);

    assign imm_o = {{(XLEN-12){imm12_i[11]}}, imm12_i};

endmodule

// File: rtl/exec_ctrl.sv
// Four-state execute sequencer (IDLE/READ/EXEC/WB) for OP and OP-IMM
// instructions; owns the ALU control inputs and the register write port.
module exec_ctrl
    import exec_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    exec_ctrl_if.master bus
);

    exec_state_e     state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            illegal_q, illegal_d;
    logic            accept_s;
    logic            is_op_s;
    logic            is_op_imm_s;
    logic            neg_s;
    logic [XLEN-1:0] imm_s;

    exec_ctrl_imm_gen imm_gen_i (
        .imm12_i (instr_q[31:20]),
        .imm_o   (imm_s)
    );

    assign accept_s    = bus.instr_valid_i && (state_q == ST_IDLE);
    assign is_op_s     = (instr_q[6:0] == OPC_OP);
    assign is_op_imm_s = (instr_q[6:0] == OPC_OP_IMM);
    // Only SRAI among the I-type ops carries the NEG modifier in its immediate.
    assign neg_s = (is_op_s && instr_q[30]) ||
                   (is_op_imm_s && (instr_q[14:12] == 3'b101) &&
                    (instr_q[31:25] == 7'b0100000));

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            instr_q   <= 32'h0000_0000;
            rd_data_q <= 32'h0000_0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rd_data_q <= rd_data_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && opc_supported(bus.instr_i[6:0])) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction capture, result capture and illegal-opcode pulse.
    always_comb begin
        instr_d   = instr_q;
        rd_data_d = rd_data_q;
        illegal_d = 1'b0;
        if (accept_s) begin
            instr_d   = bus.instr_i;
            illegal_d = !opc_supported(bus.instr_i[6:0]);
        end else begin
            instr_d   = instr_q;
            illegal_d = 1'b0;
        end
        if (state_q == ST_EXEC) begin
            rd_data_d = bus.alu_result_i;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Outputs; everything idles at zero/default outside its own state.
    always_comb begin
        bus.instr_ready_o   = 1'b0;
        bus.rs1_addr_o      = 5'd0;
        bus.rs2_addr_o      = 5'd0;
        bus.alu_operand_1_o = 32'h0000_0000;
        bus.alu_operand_2_o = 32'h0000_0000;
        bus.alu_funct3_o    = ALU_ADD;
        bus.alu_funct7_o    = F7_DEFAULT;
        bus.rd_we_o         = 1'b0;
        bus.rd_addr_o       = 5'd0;
        bus.rd_data_o       = 32'h0000_0000;
        bus.illegal_o       = illegal_q;
        bus.busy_o          = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: bus.instr_ready_o = 1'b1;
            ST_READ: begin
                bus.rs1_addr_o = instr_q[19:15];
                bus.rs2_addr_o = instr_q[24:20];
            end
            ST_EXEC: begin
                bus.alu_operand_1_o = bus.rs1_data_i;
                bus.alu_operand_2_o = is_op_imm_s ? imm_s : bus.rs2_data_i;
                bus.alu_funct3_o    = alu_funct3_e'(instr_q[14:12]);
                bus.alu_funct7_o    = neg_s ? F7_NEG : F7_DEFAULT;
            end
            ST_WB: begin
                bus.rd_addr_o = instr_q[11:7];
                bus.rd_data_o = rd_data_q;
                bus.rd_we_o   = (instr_q[11:7] != 5'd0);
            end
            default: bus.instr_ready_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a behavioural register file and ALU.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = 5'd0;
    logic [31:0] pl_data = 32'h0;
    logic [31:0] regs [32];

    exec_ctrl_if bus ();

    exec_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Register file: preload port, DUT write port, one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (bus.rd_we_o && bus.rd_addr_o != 5'd0) regs[bus.rd_addr_o] <= bus.rd_data_o;
        bus.rs1_data_i <= (bus.rs1_addr_o == 5'd0) ? 32'h0 : regs[bus.rs1_addr_o];
        bus.rs2_data_i <= (bus.rs2_addr_o == 5'd0) ? 32'h0 : regs[bus.rs2_addr_o];
    end

    // Reference ALU.
    always_comb begin
        logic [31:0] a, b;
        a = bus.alu_operand_1_o;
        b = bus.alu_operand_2_o;
        case (bus.alu_funct3_o)
            ALU_ADD:  bus.alu_result_i = (bus.alu_funct7_o == F7_NEG) ? a - b : a + b;
            ALU_SLL:  bus.alu_result_i = a << b[4:0];
            ALU_SLT:  bus.alu_result_i = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: bus.alu_result_i = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  bus.alu_result_i = a ^ b;
            ALU_SR:   bus.alu_result_i = (bus.alu_funct7_o == F7_NEG) ?
                                         32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            ALU_OR:   bus.alu_result_i = a | b;
            ALU_AND:  bus.alu_result_i = a & b;
            default:  bus.alu_result_i = 32'h0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.instr_valid_i = 1'b1;
        bus.instr_i = ins;
        step();
        bus.instr_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_valid_i = 1'b0;
        bus.instr_i = 32'h0;
        rst_ni = 1'b0;
        step(); step();
        checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.rd_we_o !== 1'b0 || bus.illegal_o !== 1'b0) begin failures++; $display("FAIL reset_pulses we=%b ill=%b exp=0/0", bus.rd_we_o, bus.illegal_o); end
        checks++; if (bus.rs1_addr_o !== 5'd0 || bus.alu_operand_2_o !== 32'h0) begin failures++; $display("FAIL reset_outs rs1=%0d op2=%h exp=0/0", bus.rs1_addr_o, bus.alu_operand_2_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_exec();
        preload(5'd1, 32'd5); preload(5'd2, 32'd7); preload(5'd3, 32'hDEADBEEF);
        issue(32'h002081B3);
        step();
        checks++; if (bus.alu_operand_1_o !== 32'd5) begin failures++; $display("FAIL rst_exec_op1 got=%h exp=5", bus.alu_operand_1_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_async rdy=%b busy=%b exp=1/0", bus.instr_ready_o, bus.busy_o); end
        checks++; if (bus.alu_operand_1_o !== 32'h0 || bus.alu_funct7_o !== F7_DEFAULT) begin failures++; $display("FAIL rst_async_alu op1=%h f7=%h exp=0/0", bus.alu_operand_1_o, bus.alu_funct7_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.rd_we_o !== 1'b0 || bus.illegal_o !== 1'b0) begin failures++; $display("FAIL rst_hold_%0d we=%b ill=%b exp=0/0", i, bus.rd_we_o, bus.illegal_o); end
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.rd_we_o !== 1'b0) begin failures++; $display("FAIL rst_after_we_%0d got=%b exp=0", i, bus.rd_we_o); end
        end
        checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.instr_ready_o); end
        checks++; if (regs[3] !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_no_write x3=%h exp=deadbeef", regs[3]); end
    endtask

    task automatic test_add();
        issue(32'h002081B3);
        checks++; if (bus.rs1_addr_o !== 5'd1 || bus.rs2_addr_o !== 5'd2) begin failures++; $display("FAIL add_read rs1=%0d rs2=%0d exp=1/2", bus.rs1_addr_o, bus.rs2_addr_o); end
        checks++; if (bus.instr_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL add_read_hs rdy=%b busy=%b exp=0/1", bus.instr_ready_o, bus.busy_o); end
        checks++; if (bus.alu_operand_1_o !== 32'h0) begin failures++; $display("FAIL add_read_quiet op1=%h exp=0", bus.alu_operand_1_o); end
        step();
        checks++; if (bus.alu_operand_1_o !== 32'd5 || bus.alu_operand_2_o !== 32'd7) begin failures++; $display("FAIL add_exec_ops op1=%h op2=%h exp=5/7", bus.alu_operand_1_o, bus.alu_operand_2_o); end
        checks++; if (bus.alu_funct3_o !== ALU_ADD || bus.alu_funct7_o !== F7_DEFAULT) begin failures++; $display("FAIL add_exec_funct f3=%h f7=%h exp=0/0", bus.alu_funct3_o, bus.alu_funct7_o); end
        checks++; if (bus.rd_we_o !== 1'b0) begin failures++; $display("FAIL add_exec_we got=%b exp=0", bus.rd_we_o); end
        step();
        checks++; if (bus.rd_we_o !== 1'b1 || bus.rd_addr_o !== 5'd3 || bus.rd_data_o !== 32'd12) begin failures++; $display("FAIL add_wb we=%b rd=%0d data=%h exp=1/3/c", bus.rd_we_o, bus.rd_addr_o, bus.rd_data_o); end
        checks++; if (bus.alu_operand_1_o !== 32'h0) begin failures++; $display("FAIL add_wb_quiet op1=%h exp=0", bus.alu_operand_1_o); end
        step();
        checks++; if (bus.rd_we_o !== 1'b0 || bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL add_idle we=%b rdy=%b busy=%b exp=0/1/0", bus.rd_we_o, bus.instr_ready_o, bus.busy_o); end
        checks++; if (regs[3] !== 32'd12) begin failures++; $display("FAIL add_regfile x3=%h exp=c", regs[3]); end
    endtask

    task automatic test_sub();
        issue(32'h40208233);
        step();
        checks++; if (bus.alu_funct7_o !== F7_NEG) begin failures++; $display("FAIL sub_f7 got=%h exp=20", bus.alu_funct7_o); end
        step();
        checks++; if (bus.rd_we_o !== 1'b1 || bus.rd_addr_o !== 5'd4 || bus.rd_data_o !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_wb we=%b rd=%0d data=%h exp=1/4/fffffffe", bus.rd_we_o, bus.rd_addr_o, bus.rd_data_o); end
        step();
    endtask

    task automatic test_addi_neg();
        preload(5'd1, 32'd0);
        issue(32'hFFF08293);
        step();
        checks++; if (bus.alu_operand_2_o !== 32'hFFFFFFFF || bus.alu_funct7_o !== F7_DEFAULT) begin failures++; $display("FAIL addi_exec op2=%h f7=%h exp=ffffffff/0", bus.alu_operand_2_o, bus.alu_funct7_o); end
        step();
        checks++; if (bus.rd_we_o !== 1'b1 || bus.rd_addr_o !== 5'd5 || bus.rd_data_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_wb we=%b rd=%0d data=%h exp=1/5/ffffffff", bus.rd_we_o, bus.rd_addr_o, bus.rd_data_o); end
        step();
    endtask

    task automatic test_srai();
        preload(5'd1, 32'h80000000);
        issue(32'h4040D393);
        step();
        checks++; if (bus.alu_operand_2_o !== 32'h00000404 || bus.alu_funct7_o !== F7_NEG || bus.alu_funct3_o !== ALU_SR) begin failures++; $display("FAIL srai_exec op2=%h f7=%h f3=%h exp=404/20/5", bus.alu_operand_2_o, bus.alu_funct7_o, bus.alu_funct3_o); end
        step();
        checks++; if (bus.rd_data_o !== 32'hF8000000 || bus.rd_addr_o !== 5'd7) begin failures++; $display("FAIL srai_wb rd=%0d data=%h exp=7/f8000000", bus.rd_addr_o, bus.rd_data_o); end
        step();
    endtask

    task automatic test_rd_zero_and_illegal();
        issue(32'h00108013);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.rd_we_o !== 1'b0 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL x0_cycle_%0d we=%b busy=%b exp=0/1", i, bus.rd_we_o, bus.busy_o); end
            step();
        end
        checks++; if (bus.rd_we_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL x0_done we=%b rdy=%b exp=0/1", bus.rd_we_o, bus.instr_ready_o); end
        preload(5'd6, 32'h12345678);
        issue(32'h0000A303);
        checks++; if (bus.illegal_o !== 1'b1) begin failures++; $display("FAIL lw_illegal got=%b exp=1", bus.illegal_o); end
        checks++; if (bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.rs1_addr_o !== 5'd0) begin failures++; $display("FAIL lw_idle rdy=%b busy=%b rs1=%0d exp=1/0/0", bus.instr_ready_o, bus.busy_o, bus.rs1_addr_o); end
        step();
        checks++; if (bus.illegal_o !== 1'b0 || bus.rd_we_o !== 1'b0) begin failures++; $display("FAIL lw_pulse_end ill=%b we=%b exp=0/0", bus.illegal_o, bus.rd_we_o); end
        step(); step();
        checks++; if (bus.rd_we_o !== 1'b0 || regs[6] !== 32'h12345678) begin failures++; $display("FAIL lw_no_write we=%b x6=%h exp=0/12345678", bus.rd_we_o, regs[6]); end
    endtask

    task automatic test_back_to_back();
        int lows;
        preload(5'd1, 32'd5); preload(5'd2, 32'd7); preload(5'd4, 32'd100);
        lows = 0;
        bus.instr_valid_i = 1'b1;
        bus.instr_i = 32'h002081B3;
        step();
        bus.instr_i = 32'h00418333;
        for (int i = 0; i < 3; i++) begin
            if (bus.instr_ready_o == 1'b0) lows++;
            step();
        end
        checks++; if (lows !== 3) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=3", lows); end
        checks++; if (bus.instr_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", bus.instr_ready_o); end
        step();
        bus.instr_valid_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1 || bus.rs1_addr_o !== 5'd3 || bus.rs2_addr_o !== 5'd4) begin failures++; $display("FAIL b2b_second_read busy=%b rs1=%0d rs2=%0d exp=1/3/4", bus.busy_o, bus.rs1_addr_o, bus.rs2_addr_o); end
        step(); step();
        checks++; if (bus.rd_we_o !== 1'b1 || bus.rd_addr_o !== 5'd6 || bus.rd_data_o !== 32'd112) begin failures++; $display("FAIL b2b_dep_wb we=%b rd=%0d data=%h exp=1/6/70", bus.rd_we_o, bus.rd_addr_o, bus.rd_data_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_add();
        test_sub();
        test_addi_neg();
        test_srai();
        test_rd_zero_and_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
